// File: rtl/icp_top_top_if.sv
// Sample-source / result-stream bundle for the ICP 8x8 matrix-by-vector block.
// valid/ready: there is no ready; a sample is taken on every rising edge where valid_input=1 in LOAD.
interface icp_top_top_if;
    logic       start_in;
    logic       valid_input;
    logic [6:0] X_load;
    logic       finish;
    logic       P_out;

    modport master (
        output start_in,
        output valid_input,
        output X_load,
        input  finish,
        input  P_out
    );

    modport slave (
        input  start_in,
        input  valid_input,
        input  X_load,
        output finish,
        output P_out
    );
endinterface

// File: rtl/icp_top_top.sv
// ICP top: accumulates P[r] = sum_c X[r][c]*K[c] over 64 streamed samples, then serialises P[0..7].
// Optional macro ICP_LSB_FIRST_EN: each result word is sent LSB first instead of MSB first.
module icp_top_top #(
    parameter logic [3:0] K0    = 4'd1,
    parameter logic [3:0] K1    = 4'd2,
    parameter logic [3:0] K2    = 4'd3,
    parameter logic [3:0] K3    = 4'd4,
    parameter logic [3:0] K4    = 4'd5,
    parameter logic [3:0] K5    = 4'd6,
    parameter logic [3:0] K6    = 4'd7,
    parameter logic [3:0] K7    = 4'd8,
    parameter int         RES_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    icp_top_top_if.slave      bus,
    output logic [1:0]        state_o
);

    localparam int BW = (RES_W > 1) ? $clog2(RES_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [5:0]       n_q, n_d;
    logic [2:0]       word_q, word_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [RES_W-1:0] acc_q [8];
    logic [RES_W-1:0] acc_d [8];
    logic             p_out_q, p_out_d;
    logic             finish_q, finish_d;
    logic [10:0]      prod;

    function automatic logic [3:0] coef(input logic [2:0] c);
        case (c)
            3'd0:    coef = K0;
            3'd1:    coef = K1;
            3'd2:    coef = K2;
            3'd3:    coef = K3;
            3'd4:    coef = K4;
            3'd5:    coef = K5;
            3'd6:    coef = K6;
            default: coef = K7;
        endcase
    endfunction

    // b is the position within the word in transmission order.
    function automatic logic pick(input logic [RES_W-1:0] w, input logic [BW-1:0] b);
`ifdef ICP_LSB_FIRST_EN
        pick = w[b];
`else
        logic [BW-1:0] idx;
        idx  = BW'(RES_W - 1) - b;
        pick = w[idx];
`endif
    endfunction

    assign prod = 11'(bus.X_load) * 11'(coef(n_q[2:0]));

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        word_d   = word_q;
        bit_d    = bit_q;
        acc_d    = acc_q;
        p_out_d  = 1'b0;
        finish_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    state_d = LOAD;
                    n_d     = '0;
                    for (int i = 0; i < 8; i++) acc_d[i] = '0;
                end
            end
            LOAD: begin
                if (bus.valid_input) begin
                    acc_d[n_q[5:3]] = acc_q[n_q[5:3]] + RES_W'(prod);
                    n_d             = n_q + 6'd1;
                    if (n_q == 6'd63) begin
                        // First result bit must be on P_out right after the last sample edge.
                        state_d = SHIFT;
                        word_d  = '0;
                        bit_d   = '0;
                        p_out_d = pick(acc_d[0], '0);
                    end
                end
            end
            SHIFT: begin
                if (bit_q == BW'(RES_W - 1)) begin
                    if (word_q == 3'd7) begin
                        state_d  = DONE;
                        finish_d = 1'b1;
                    end else begin
                        word_d  = word_q + 3'd1;
                        bit_d   = '0;
                        p_out_d = pick(acc_q[word_q + 3'd1], '0);
                    end
                end else begin
                    bit_d   = bit_q + BW'(1);
                    p_out_d = pick(acc_q[word_q], bit_q + BW'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            n_q      <= '0;
            word_q   <= '0;
            bit_q    <= '0;
            p_out_q  <= 1'b0;
            finish_q <= 1'b0;
            for (int i = 0; i < 8; i++) acc_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            word_q   <= word_d;
            bit_q    <= bit_d;
            p_out_q  <= p_out_d;
            finish_q <= finish_d;
            acc_q    <= acc_d;
        end
    end

    assign bus.P_out  = p_out_q;
    assign bus.finish = finish_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_icp_top_top.sv
// Directed bench for icp_top_top: scoreboarded result words, finish timing, bubbles and abort-by-reset.
module tb_icp_top_top;

    localparam int W = 16;

    logic       clk;
    logic       rst;
    logic [1:0] state_dbg;
    int         cyc;
    int         checks;
    int         errors;

    logic [W-1:0] exp_q[$];
    logic [6:0]   samp [64];
    int           kc   [8] = '{1, 2, 3, 4, 5, 6, 7, 8};

    icp_top_top_if bus ();

    icp_top_top dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: row sums of the current sample table, pushed in transmission order.
    task automatic push_expected();
        for (int r = 0; r < 8; r++) begin
            int s;
            s = 0;
            for (int c = 0; c < 8; c++) s += int'(samp[8*r+c]) * kc[c];
            exp_q.push_back(W'(s));
        end
    endtask

    task automatic run_job(input string name, input bit bub);
        int          c0;
        int          load_edges;
        logic [W-1:0] word;
        logic [W-1:0] exp;
        load_edges = bub ? 127 : 64;
        push_expected();
        @(negedge clk);
        bus.start_in    = 1'b1;
        bus.valid_input = 1'b0;
        @(posedge clk);
        #1 c0 = cyc;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.start_in    = 1'b0;
            bus.valid_input = 1'b1;
            bus.X_load      = samp[i];
            if (i == 10) begin
                chk({name, " p_out_load"}, 32'(bus.P_out), 32'd0);
                chk({name, " finish_load"}, 32'(bus.finish), 32'd0);
            end
            @(posedge clk);
            if (bub && i != 63) begin
                @(negedge clk);
                bus.valid_input = 1'b0;
                bus.X_load      = 7'($urandom_range(0, 127));
                @(posedge clk);
            end
        end
        @(negedge clk);
        bus.valid_input = 1'b0;
        bus.X_load      = '0;
        word            = '0;
        for (int k = 0; k < 8 * W; k++) begin
            int b;
            if (k > 0) @(negedge clk);
            b = k % W;
`ifdef ICP_LSB_FIRST_EN
            word[b] = bus.P_out;
`else
            word[W-1-b] = bus.P_out;
`endif
            if (b == W - 1) begin
                exp = exp_q.pop_front();
                chk($sformatf("%s word%0d", name, k / W), 32'(word), 32'(exp));
                word = '0;
            end
        end
        @(negedge clk);
        chk({name, " finish_pulse"}, 32'(bus.finish), 32'd1);
        chk({name, " latency"}, 32'(cyc - c0), 32'(load_edges + 128));
        @(negedge clk);
        chk({name, " finish_low"}, 32'(bus.finish), 32'd0);
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        rst             = 1'b0;
        bus.start_in    = 1'b0;
        bus.valid_input = 1'b0;
        bus.X_load      = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst finish", 32'(bus.finish), 32'd0);
        chk("rst p_out", 32'(bus.P_out), 32'd0);
        chk("rst state", 32'(state_dbg), 32'd0);
        rst = 1'b1;

        // all ones: every word 36
        for (int i = 0; i < 64; i++) samp[i] = 7'd1;
        run_job("ones", 1'b0);

        // worst case: every word 4572
        for (int i = 0; i < 64; i++) samp[i] = 7'd127;
        run_job("max", 1'b0);

        // row r filled with r: words 0,36,...,252
        for (int i = 0; i < 64; i++) samp[i] = 7'(i / 8);
        run_job("rows", 1'b0);

        // first/last sample only, with bubbles every other cycle
        for (int i = 0; i < 64; i++) samp[i] = 7'd0;
        samp[0]  = 7'd5;
        samp[63] = 7'd3;
        run_job("bubble", 1'b1);

        // abort after 20 samples
        @(negedge clk);
        bus.start_in = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.start_in    = 1'b0;
            bus.valid_input = 1'b1;
            bus.X_load      = 7'($urandom_range(1, 127));
            @(posedge clk);
        end
        @(negedge clk);
        bus.valid_input = 1'b0;
        rst             = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort finish", 32'(bus.finish), 32'd0);
        chk("abort p_out", 32'(bus.P_out), 32'd0);
        chk("abort state", 32'(state_dbg), 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 64; i++) samp[i] = 7'd1;
        run_job("after_abort", 1'b0);

        chk("queue empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
